lite_write_ctrl: RTL and testbench

LITE_WRITE_CTRL -- requirements
Module: lite_write_ctrl

---
 rtl/lite_write_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lite_write_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lite_write_ctrl.sv
// AXI-Lite register programming sequence for an S2MM DMA channel with idle polling.
// Define LITE_WRITE_CTRL_IRQ_CLR_EN to add an IOC clear write before completion.
module lite_write_ctrl #(
    parameter logic [9:0]  ADDR_DMACR = 10'h030,
    parameter logic [9:0]  ADDR_DA    = 10'h048,
    parameter logic [9:0]  ADDR_LEN   = 10'h058,
    parameter logic [9:0]  ADDR_DMASR = 10'h034,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  m_axi_lite_awaddr,
    output logic        m_axi_lite_awvalid,
    input  logic        m_axi_lite_awready,
    output logic [31:0] m_axi_lite_wdata,
    output logic        m_axi_lite_wvalid,
    input  logic        m_axi_lite_wready,
    input  logic [1:0]  m_axi_lite_bresp,
    input  logic        m_axi_lite_bvalid,
    output logic        m_axi_lite_bready,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [25:0] cmd_len,
    output logic        poll_start,
    input  logic        dma_idle,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_CR,
        WR_DA,
        WR_LEN,
        WAIT_IDLE,
        CLR_IRQ,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        err_q;
    logic        err_nxt;
    logic [31:0] addr_q;
    logic [25:0] len_q;
    logic [15:0] cnt;
    logic        issued;
    logic        aw_pend;
    logic        w_pend;
    logic        aw_ok;
    logic        w_ok;
    logic        in_wr;
    logic        wr_done;
    logic        bad_resp;
    logic        timed_out;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    assign in_wr = (state == WR_CR) || (state == WR_DA) ||
                   (state == WR_LEN) || (state == CLR_IRQ);
    assign wr_done   = m_axi_lite_bvalid & m_axi_lite_bready;
    assign bad_resp  = (m_axi_lite_bresp != 2'b00);
    assign timed_out = (cnt == TIMEOUT - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = WR_CR;
                    err_nxt   = 1'b0;
                end
            end
            WR_CR: begin
                if (wr_done) state_nxt = WR_DA;
            end
            WR_DA: begin
                if (wr_done) state_nxt = WR_LEN;
            end
            WR_LEN: begin
                if (wr_done) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // an idle pulse on the last allowed cycle still counts as success
                if (dma_idle) begin
`ifdef LITE_WRITE_CTRL_IRQ_CLR_EN
                    state_nxt = CLR_IRQ;
`else
                    state_nxt = DONE;
`endif
                end else if (timed_out) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            CLR_IRQ: begin
                if (wr_done) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (in_wr && wr_done && bad_resp) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
            end
            if (state == WAIT_IDLE) cnt <= cnt + 16'd1;
            else                    cnt <= '0;
        end
    end

    // One write per WR state: issue one cycle after entry, never re-issue.
    always_ff @(posedge clk) begin
        if (rst || !in_wr || wr_done) begin
            issued  <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
        end else begin
            if (!issued) begin
                issued  <= 1'b1;
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end
            if (aw_pend && m_axi_lite_awready) begin
                aw_pend <= 1'b0;
                aw_ok   <= 1'b1;
            end
            if (w_pend && m_axi_lite_wready) begin
                w_pend <= 1'b0;
                w_ok   <= 1'b1;
            end
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        unique case (state)
            WR_CR: begin
                wr_addr = ADDR_DMACR;
                wr_data = 32'h0000_0001;
            end
            WR_DA: begin
                wr_addr = ADDR_DA;
                wr_data = addr_q;
            end
            WR_LEN: begin
                wr_addr = ADDR_LEN;
                wr_data = {6'b0, len_q};
            end
            CLR_IRQ: begin
                wr_addr = ADDR_DMASR;
                wr_data = 32'h0000_1000;
            end
            default: begin
                wr_addr = '0;
                wr_data = '0;
            end
        endcase
    end

    assign m_axi_lite_awvalid = aw_pend;
    assign m_axi_lite_wvalid  = w_pend;
    assign m_axi_lite_awaddr  = aw_pend ? wr_addr : '0;
    assign m_axi_lite_wdata   = w_pend ? wr_data : '0;
    assign m_axi_lite_bready  = aw_ok & w_ok;

    assign cmd_ready  = (state == IDLE);
    assign poll_start = (state == WAIT_IDLE);
    assign done       = (state == DONE);
    assign err        = (state == DONE) & err_q;

endmodule

// File: tb/tb_lite_write_ctrl.sv
// Randomized bench for lite_write_ctrl: reactive AXI-Lite slave plus a
// transaction-level model of the expected register writes and outcome.
module tb_lite_write_ctrl;

    localparam logic [15:0] TO = 16'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  m_axi_lite_awaddr;
    logic        m_axi_lite_awvalid;
    logic        m_axi_lite_awready;
    logic [31:0] m_axi_lite_wdata;
    logic        m_axi_lite_wvalid;
    logic        m_axi_lite_wready;
    logic [1:0]  m_axi_lite_bresp;
    logic        m_axi_lite_bvalid;
    logic        m_axi_lite_bready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [25:0] cmd_len;
    logic        poll_start;
    logic        dma_idle;
    logic        done;
    logic        err;

    lite_write_ctrl #(.TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .m_axi_lite_awaddr  (m_axi_lite_awaddr),
        .m_axi_lite_awvalid (m_axi_lite_awvalid),
        .m_axi_lite_awready (m_axi_lite_awready),
        .m_axi_lite_wdata   (m_axi_lite_wdata),
        .m_axi_lite_wvalid  (m_axi_lite_wvalid),
        .m_axi_lite_wready  (m_axi_lite_wready),
        .m_axi_lite_bresp   (m_axi_lite_bresp),
        .m_axi_lite_bvalid  (m_axi_lite_bvalid),
        .m_axi_lite_bready  (m_axi_lite_bready),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .poll_start         (poll_start),
        .dma_idle           (dma_idle),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit irq_en;

    // slave state
    bit          aw_got, w_got, b_fire;
    int          aw_del, w_del, b_del, aw_req, w_req, aw_cyc, w_cyc;
    int          fix_aw = -1, fix_w = -1, fix_b = -1;
    logic [9:0]  aw_a;
    logic [31:0] w_d;
    logic [1:0]  resp_q[$];
    logic [9:0]  obs_a[$];
    logic [31:0] obs_d[$];

    // per-command plan
    logic [1:0]  plan_resp [4];
    int          plan_d;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic new_delays();
        aw_req = (fix_aw >= 0) ? fix_aw : int'($urandom_range(0, 3));
        w_req  = (fix_w >= 0) ? fix_w : int'($urandom_range(0, 3));
        b_del  = (fix_b >= 0) ? fix_b : int'($urandom_range(0, 2));
        aw_del = aw_req;
        w_del  = w_req;
        aw_cyc = 0;
        w_cyc  = 0;
    endtask

    task automatic slave_reset();
        m_axi_lite_awready = 1'b0;
        m_axi_lite_wready  = 1'b0;
        m_axi_lite_bvalid  = 1'b0;
        m_axi_lite_bresp   = 2'b00;
        aw_got = 0;
        w_got  = 0;
        b_fire = 0;
        resp_q.delete();
        new_delays();
    endtask

    // Runs at the falling edge; decisions take effect at the next rising edge.
    task automatic slave_step();
        if (b_fire) begin
            m_axi_lite_bvalid = 1'b0;
            m_axi_lite_bresp  = 2'b00;
            b_fire = 0;
            aw_got = 0;
            w_got  = 0;
            new_delays();
        end
        check("bready_gate", m_axi_lite_bready, aw_got && w_got);
        if (!aw_got && !w_got)
            check("valid_pair", m_axi_lite_awvalid, m_axi_lite_wvalid);
        if (aw_got && w_got) begin
            if (b_del > 0) b_del--;
            else begin
                if (!m_axi_lite_bvalid) begin
                    m_axi_lite_bvalid = 1'b1;
                    m_axi_lite_bresp  = resp_q.size() > 0 ? resp_q.pop_front() : 2'b00;
                end
                if (m_axi_lite_bready) begin
                    b_fire = 1;
                    obs_a.push_back(aw_a);
                    obs_d.push_back(w_d);
                end
            end
        end
        m_axi_lite_awready = 1'b0;
        if (aw_got) check("aw_redrive", m_axi_lite_awvalid, 0);
        else if (m_axi_lite_awvalid) begin
            aw_cyc++;
            if (aw_del > 0) aw_del--;
            else begin
                m_axi_lite_awready = 1'b1;
                aw_got = 1;
                aw_a   = m_axi_lite_awaddr;
                check("aw_hold", aw_cyc, aw_req + 1);
            end
        end
        m_axi_lite_wready = 1'b0;
        if (w_got) check("w_redrive", m_axi_lite_wvalid, 0);
        else if (m_axi_lite_wvalid) begin
            w_cyc++;
            if (w_del > 0) w_del--;
            else begin
                m_axi_lite_wready = 1'b1;
                w_got = 1;
                w_d   = m_axi_lite_wdata;
                check("w_hold", w_cyc, w_req + 1);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        slave_step();
        if (!m_axi_lite_awvalid) check("awaddr_zero", m_axi_lite_awaddr, 0);
        if (!m_axi_lite_wvalid) check("wdata_zero", m_axi_lite_wdata, 0);
        if (!done) check("err_wo_done", err, 0);
    endtask

    task automatic plan_ok(input int d);
        for (int i = 0; i < 4; i++) plan_resp[i] = 2'b00;
        plan_d = d;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [25:0] l);
        logic [9:0]  ea [4];
        logic [31:0] ed [4];
        int fe, n_exp, e, pc, dcyc, poll_exp, n_cmp;
        bit seen, got, derr, success, werr, err_exp;
        ea[0] = 10'h030; ed[0] = 32'h0000_0001;
        ea[1] = 10'h048; ed[1] = a;
        ea[2] = 10'h058; ed[2] = {6'b0, l};
        ea[3] = 10'h034; ed[3] = 32'h0000_1000;
        fe = -1;
        for (int i = 0; i < 3; i++)
            if (fe < 0 && plan_resp[i] != 2'b00) fe = i;
        werr     = (fe >= 0);
        success  = !werr && (plan_d < int'(TO));
        n_exp    = werr ? fe + 1 : ((success && irq_en) ? 4 : 3);
        err_exp  = werr || !success || (irq_en && plan_resp[3] != 2'b00);
        poll_exp = werr ? 0 : (success ? plan_d + 1 : int'(TO));

        resp_q.delete();
        for (int i = 0; i < 4; i++) resp_q.push_back(plan_resp[i]);
        obs_a.delete();
        obs_d.delete();

        for (int k = 0; k < 50 && !cmd_ready; k++) step();
        check("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        dma_idle  = 1'b0;
        seen = 0; got = 0; derr = 0; pc = 0; e = 0; dcyc = 0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (k == 0) check("accepted", cmd_ready, 0);
            if (poll_start) begin
                if (!seen) begin
                    seen = 1;
                    e    = cyc;
                end
                pc++;
            end
            if (done) begin
                got  = 1;
                dcyc = cyc;
                derr = err;
            end
            cmd_valid = !cmd_ready && ($urandom_range(0, 3) == 0);
            cmd_addr  = $urandom;
            cmd_len   = 26'($urandom);
            if (seen && poll_start && cyc == e + plan_d) dma_idle = 1'b1;
            else dma_idle = !poll_start && ($urandom_range(0, 3) == 0);
        end
        check("done_seen", got, 1);
        check("err", derr, err_exp);
        check("poll_len", pc, poll_exp);
        check("n_writes", obs_a.size(), n_exp);
        n_cmp = obs_a.size() < n_exp ? obs_a.size() : n_exp;
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("wr%0d_addr", i), obs_a[i], ea[i]);
            check($sformatf("wr%0d_data", i), obs_d[i], ed[i]);
        end
        if (!werr && !(irq_en && success))
            check("done_lat", dcyc - e, poll_exp);

        step();
        cmd_valid = 1'b0;
        dma_idle  = 1'b0;
        check("done_pulse", done, 0);
        check("back_idle", cmd_ready, 1);
        step();
        check("not_queued", cmd_ready, 1);
    endtask

    task automatic reset_mid_len();
        bit hit;
        plan_ok(5);
        resp_q.delete();
        obs_a.delete();
        obs_d.delete();
        for (int k = 0; k < 50 && !cmd_ready; k++) step();
        cmd_valid = 1'b1;
        cmd_addr  = 32'hDEAD_0000;
        cmd_len   = 26'd64;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            step();
            cmd_valid = 1'b0;
            if (obs_a.size() == 2 && m_axi_lite_awvalid) hit = 1;
        end
        check("rst_hit", hit, 1);
        rst = 1'b1;
        slave_reset();
        step();
        check("rst_awvalid", m_axi_lite_awvalid, 0);
        check("rst_wvalid", m_axi_lite_wvalid, 0);
        check("rst_bready", m_axi_lite_bready, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_poll", poll_start, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_quiet", {m_axi_lite_awvalid, done, poll_start}, 0);
        end
        check("rst_no_len", obs_a.size(), 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LITE_WRITE_CTRL_IRQ_CLR_EN
        irq_en = 1'b1;
`else
        irq_en = 1'b0;
`endif
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        dma_idle  = 1'b0;
        slave_reset();
        repeat (3) step();
        rst = 1'b0;
        check("rst_state", {cmd_ready, m_axi_lite_awvalid, m_axi_lite_wvalid,
                            m_axi_lite_bready, poll_start, done, err}, 7'b1000000);

        fix_aw = 0; fix_w = 0; fix_b = 0; new_delays();
        plan_ok(5);
        run_cmd(32'h1000_0000, 26'd4096);

        fix_aw = 3; fix_w = 0; fix_b = 0; new_delays();
        plan_ok(3);
        run_cmd(32'h2000_0040, 26'd256);

        fix_aw = -1; fix_w = -1; fix_b = -1; new_delays();
        plan_ok(4); plan_resp[1] = 2'b10;
        run_cmd(32'h3000_0000, 26'd128);

        plan_ok(100);
        run_cmd(32'h4000_0000, 26'd512);
        plan_ok(19);
        run_cmd(32'h5000_0000, 26'd1);
        plan_ok(20);
        run_cmd(32'h6000_0000, 26'd2);
        plan_ok(0);
        run_cmd(32'hFFFF_FFFF, 26'd0);
        plan_ok(7);
        run_cmd(32'h0000_0004, 26'h3FF_FFFF);
        plan_ok(2); plan_resp[0] = 2'b01;
        run_cmd(32'h7000_0000, 26'd8);
        plan_ok(6); plan_resp[3] = 2'b11;
        run_cmd(32'h8000_0000, 26'd16);

        reset_mid_len();
        plan_ok(1);
        run_cmd(32'h9000_0000, 26'd32);

        for (int n = 0; n < 40; n++) begin
            plan_ok(int'($urandom_range(0, 24)));
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0)
                    plan_resp[i] = 2'($urandom_range(1, 3));
            run_cmd($urandom, 26'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
